ly_oneshot_dt: RTL



---
 rtl/ly_oneshot_dt_if.sv | 25 ++
 rtl/ly_oneshot_dt.sv | 71 +++++++
 2 files changed

// File: rtl/ly_oneshot_dt_if.sv
// ly_oneshot_dt_if: control, hit and status signals of the dead-time one-shot
interface ly_oneshot_dt_if #(
   parameter int WIDTH     = 224,
   parameter int CNT_BITS  = 4,
   parameter int DROP_BITS = 16
);
   logic [CNT_BITS-1:0]  i_persist;
   logic [CNT_BITS-1:0]  i_deadtime;
   logic                 i_retrig;
   logic                 i_edge_mode;
   logic [WIDTH-1:0]     i_mask;
   logic [WIDTH-1:0]     i_in;
   logic                 i_drop_clr;
   logic [WIDTH-1:0]     o_out;
   logic [WIDTH-1:0]     o_busy;
   logic [DROP_BITS-1:0] o_drop_cnt;
   modport master (
      output i_persist, i_deadtime, i_retrig, i_edge_mode, i_mask, i_in, i_drop_clr,
      input  o_out, o_busy, o_drop_cnt
   );
   modport slave (
      input  i_persist, i_deadtime, i_retrig, i_edge_mode, i_mask, i_in, i_drop_clr,
      output o_out, o_busy, o_drop_cnt
   );
endinterface

// File: rtl/ly_oneshot_dt.sv
// ly_oneshot_dt: per-bit hit stretcher with dead time, retrigger, edge mode, mask and drop counter
module ly_oneshot_dt #(
   parameter int WIDTH     = 224,
   parameter int CNT_BITS  = 4,
   parameter int DROP_BITS = 16
) (
   input logic           clock,
   input logic           reset,
   ly_oneshot_dt_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] DEAD   = 2'd2;

   logic [WIDTH-1:0]     r_in_q;
   logic [WIDTH-1:0]     w_t;
   logic [WIDTH-1:0]     w_out;
   logic [WIDTH-1:0]     w_busy;
   logic [WIDTH-1:0]     w_drop;
   logic [DROP_BITS-1:0] r_drop_cnt;

   assign w_t            = ~bus.i_mask & (bus.i_edge_mode ? bus.i_in & ~r_in_q : bus.i_in);
   assign bus.o_out      = w_out;
   assign bus.o_busy     = w_busy;
   assign bus.o_drop_cnt = r_drop_cnt;

   // previous input sample for rising-edge detection, taken regardless of mask or state
   always_ff @(posedge clock)
      r_in_q <= reset ? '0 : bus.i_in;

   // any channel dropping a trigger counts the cycle once; clear beats increment
   always_ff @(posedge clock)
      r_drop_cnt <= (reset | bus.i_drop_clr) ? '0 :
                    (|w_drop & ~&r_drop_cnt) ? r_drop_cnt + 1'b1 : r_drop_cnt;

   genvar g;
   for (g = 0; g < WIDTH; g++) begin : g_ch
      logic [1:0]          r_state;
      logic [1:0]          w_state_nx;
      logic [CNT_BITS-1:0] r_cnt;
      logic [CNT_BITS-1:0] w_cnt_nx;
      logic                w_go;
      logic                w_end;

      // w_go loads persist; persist==0 on a load falls straight into the end-of-pulse path
      assign w_go      = w_t[g] & (r_state == IDLE | (r_state == ACTIVE & bus.i_retrig));
      assign w_end     = w_go ? ~|bus.i_persist : (r_state == ACTIVE & r_cnt == CNT_BITS'(1));
      assign w_out[g]  = ~reset & (r_state == ACTIVE | (r_state == IDLE & w_t[g]));
      assign w_busy[g] = ~reset & (r_state != IDLE);
      assign w_drop[g] = w_t[g] & (r_state == DEAD | (r_state == ACTIVE & ~bus.i_retrig));

      // next state: load, end of pulse into dead time or idle, else count down
      always_comb begin
         w_state_nx = (r_state == DEAD & r_cnt == CNT_BITS'(1)) ? IDLE : r_state;
         w_cnt_nx   = (r_state == IDLE) ? r_cnt : r_cnt - 1'b1;
         if (w_go & |bus.i_persist) begin
            w_state_nx = ACTIVE;
            w_cnt_nx   = bus.i_persist;
         end else if (w_end) begin
            w_state_nx = |bus.i_deadtime ? DEAD : IDLE;
            w_cnt_nx   = bus.i_deadtime;
         end
      end

      // channel state register
      always_ff @(posedge clock) begin
         r_state <= reset ? IDLE : w_state_nx;
         r_cnt   <= reset ? '0 : w_cnt_nx;
      end
   end
endmodule
